// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-organised backing RAM responder with programmable access latency
//
// Services single outstanding fetch/load/store requests from the multi-cycle RV32 core.
// The request is latched on accept, the RAM access happens LATENCY edges later, and the
// response is held until the core takes it.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid/ready   request handshake; ready only in IDLE
//   req_we            1 = store, 0 = read
//   req_addr          byte address
//   req_wdata/wstrb   store data and byte-lane enables
//   resp_valid/ready  response handshake
//   resp_rdata        read data, 0 for stores and errors
//   resp_err          misaligned or out-of-range access
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    // Byte span of the RAM, one bit wider than an address so it never wraps.
    localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic [31:0]   r_resp_rdata;
    logic          r_resp_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [1:0]    w_next_state;
    logic          w_accept;
    logic          w_access;
    logic [31:0]   w_off;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    assign w_accept = (r_state == S_IDLE) && r_req_ready && req_valid;
    assign w_access = (r_state == S_BUSY) && (r_cnt == '0);

    // Offset wraps for addresses below BASE_ADDR, which then land above SPAN.
    assign w_off = r_addr - BASE_ADDR;
    assign w_err = (r_addr[1:0] != 2'b00) || ({1'b0, w_off} >= SPAN);
    assign w_idx = w_off[AW+1:2];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_next_state = S_RESP;
            S_RESP:  if (resp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            // Registered so ready stays low until the first edge after reset release
            // and rises only the cycle after a response handshake.
            r_req_ready  <= (w_next_state == S_IDLE);
            r_resp_valid <= (w_next_state == S_RESP);

            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_access) begin
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_err || r_we) ? 32'h0 : r_mem[w_idx];
            end
        end
    end

    // RAM has no reset; it is only written on the BUSY->RESP edge, so a reset
    // before that edge leaves memory untouched.
    always_ff @(posedge clk) begin
        if (w_access && r_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard testbench for mem_responder
module tb_mem_responder;

    localparam int          DEPTH = 1024;
    localparam int          LAT   = 3;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl[int];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          rr_mode   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_evt(input string name);
        total_cnt++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    // Reference model: flat word map keyed by word index relative to BASE.
    task automatic model_apply(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, output exp_t e);
        logic [31:0] off;
        logic [31:0] mask;
        logic [31:0] word;
        int          idx;
        bit          err;
        off = addr - BASE;
        err = (addr % 4 != 0) || (off >= 32'(4 * DEPTH));
        idx = int'(off / 4);
        e.rdata = 32'h0;
        e.err   = err;
        if (!err) begin
            if (we) begin
                mask = 32'h0;
                for (int i = 0; i < 4; i++) if (wstrb[i]) mask = mask | (32'hFF << (8 * i));
                word = mdl.exists(idx) ? mdl[idx] : 32'h0;
                mdl[idx] = (word & ~mask) | (wdata & mask);
            end else begin
                e.rdata = mdl.exists(idx) ? mdl[idx] : 32'h0;
            end
        end
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb);
        exp_t e;
        bit   done;
        done = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (req_ready) begin
                model_apply(we, addr, wdata, wstrb, e);
                e.acc = cyc + 1;
                sb.push_back(e);
                done = 1;
            end
        end
        if (!done) fail_evt("req_accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            fail_evt("drain_timeout");
            sb.delete();
        end
    endtask

    task automatic wait_resp_valid();
        bit seen;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        if (!seen) fail_evt("resp_valid_timeout");
    endtask

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'($urandom_range(0, 1));
            default: resp_ready = 1'b0;
        endcase
    end

    // Monitor: samples mid-cycle, pops the scoreboard on each response handshake.
    bit          mon_pv   = 0;
    bit          mon_hold = 0;
    logic [31:0] mon_hd;
    logic        mon_he;

    always @(negedge clk) begin
        if (rst) begin
            mon_pv   = 0;
            mon_hold = 0;
        end else begin
            if (mon_hold) begin
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_rdata", resp_rdata, mon_hd);
                chk("hold_err", 32'(resp_err), 32'(mon_he));
            end
            mon_hold = 0;
            if (resp_valid) begin
                chk("req_ready_low_in_resp", 32'(req_ready), 32'd0);
                if (sb.size() == 0) begin
                    if (!mon_pv) fail_evt("spurious_response");
                end else begin
                    if (!mon_pv) chk("latency", 32'(cyc - sb[0].acc), 32'(LAT));
                    if (resp_ready) begin
                        chk("rdata", resp_rdata, sb[0].rdata);
                        chk("err", 32'(resp_err), 32'(sb[0].err));
                        void'(sb.pop_front());
                    end else begin
                        mon_hold = 1;
                        mon_hd   = resp_rdata;
                        mon_he   = resp_err;
                    end
                end
            end
            mon_pv = resp_valid;
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          r;

        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = BASE;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        resp_ready = 1'b1;

        // Reset with a pending request: nothing accepted, outputs idle.
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_rdata", resp_rdata, 32'h0);
            chk("rst_err", 32'(resp_err), 32'd0);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready_before_clk", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_after_clk", 32'(req_ready), 32'd1);

        // Latency and full-word write/read.
        do_req(1, BASE + 32'h10, 32'hDEADBEEF, 4'b1111);
        do_req(0, BASE + 32'h10, 32'h0, 4'b0000);
        drain();

        // Byte lanes.
        do_req(1, BASE + 32'h20, 32'h11223344, 4'b1111);
        do_req(1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101);
        do_req(0, BASE + 32'h20, 32'h0, 4'b0000);
        do_req(1, BASE + 32'h20, 32'h99999999, 4'b0000);
        do_req(0, BASE + 32'h20, 32'h0, 4'b0000);
        drain();

        // Errors: misaligned, past end, below base.
        do_req(0, BASE + 32'h22, 32'h0, 4'b0000);
        do_req(0, BASE + 32'(4 * DEPTH), 32'h0, 4'b0000);
        do_req(1, BASE + 32'h23, 32'hFFFFFFFF, 4'b1111);
        do_req(0, BASE + 32'h20, 32'h0, 4'b0000);
        do_req(0, BASE - 32'h4, 32'h0, 4'b0000);
        do_req(1, BASE + 32'(4 * DEPTH), 32'h12121212, 4'b1111);
        do_req(0, BASE + 32'(4 * DEPTH - 4), 32'h0, 4'b0000);
        drain();

        // Backpressure: monitor checks stability each held cycle.
        rr_mode = 2;
        do_req(0, BASE + 32'h10, 32'h0, 4'b0000);
        wait_resp_valid();
        repeat (10) @(negedge clk);
        chk("bp_ready_held_low", 32'(req_ready), 32'd0);
        rr_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_ready_after", 32'(req_ready), 32'd1);
        chk("bp_valid_after", 32'(resp_valid), 32'd0);
        drain();

        // Reset while BUSY: pending write discarded, no response.
        do_req(1, BASE + 32'h30, 32'hCAFEF00D, 4'b1111);
        drain();
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = BASE + 32'h30;
        req_wdata = 32'h55555555;
        req_wstrb = 4'b1111;
        r = 0;
        for (int k = 0; k < 50 && r == 0; k++) begin
            @(negedge clk);
            if (req_ready) r = 1;
        end
        if (r == 0) fail_evt("midrst_accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        do_req(0, BASE + 32'h30, 32'h0, 4'b0000);
        drain();

        // Reset while RESP: response dropped, RAM already written.
        rr_mode = 2;
        do_req(1, BASE + 32'h40, 32'h12345678, 4'b1111);
        wait_resp_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        if (sb.size() > 0) void'(sb.pop_front());
        @(posedge clk); #1;
        rst     = 1'b0;
        rr_mode = 0;
        @(negedge clk);
        chk("resprst_valid_low", 32'(resp_valid), 32'd0);
        do_req(0, BASE + 32'h40, 32'h0, 4'b0000);
        drain();

        // Randomized traffic over a 16-word window plus error addresses.
        for (int i = 0; i < 16; i++) do_req(1, BASE + 32'h100 + 32'(4 * i), $urandom, 4'b1111);
        rr_mode = 1;
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            d = $urandom;
            s = 4'($urandom);
            if (r == 0) begin
                case ($urandom_range(0, 2))
                    0:       a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                    1:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
                    default: a = BASE - 32'(4 * $urandom_range(1, 64));
                endcase
            end else begin
                a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 15));
            end
            do_req(1'($urandom_range(0, 1)), a, d, s);
        end
        drain();
        rr_mode = 0;

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
